// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Constants shared by the servo ramp scheduler and its step unit: the channel
// count, duty width, CPU word addresses of the register window and the sweep
// FSM state encoding.
// -----------------------------------------------------------------------------
package servo_pkg;

    localparam int NUM_SERVO = 3;
    localparam int DUTY_W    = 10;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;

    // CPU data-memory word addresses decoded by the scheduler
    localparam logic [ADDR_W-1:0] ADDR_TGT1   = 12'd11;
    localparam logic [ADDR_W-1:0] ADDR_TGT2   = 12'd12;
    localparam logic [ADDR_W-1:0] ADDR_TGT3   = 12'd13;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 12'd14;

    // One state per channel update plus the idle wait for the next tick
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } servo_state_t;

    // Channel index served by a sweep state; IDLE maps to channel 0 so the
    // shared step unit always has a defined operand.
    function automatic logic [1:0] state_chan(input servo_state_t s);
        logic [1:0] ch;
        case (s)
            ST_S2:   ch = 2'd1;
            ST_S3:   ch = 2'd2;
            default: ch = 2'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/servo_step_unit.sv
// -----------------------------------------------------------------------------
// servo_step_unit
// Combinational saturating step of a duty value toward its target. The move
// is at most STEP per call and never overshoots the target. Arithmetic is done
// one bit wider than the duty so cur+STEP and target+STEP cannot wrap.
//
// Ports
//   cur  : current duty
//   tgt  : target duty
//   next : duty after one step toward tgt (equal to cur when already there)
// -----------------------------------------------------------------------------
module servo_step_unit
    import servo_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] tgt,
    output logic [DUTY_W-1:0] next
);

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP);

    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] tgt_x;
    logic [DUTY_W:0] up_x;
    logic [DUTY_W:0] dn_x;
    logic [DUTY_W:0] dn_lim_x;

    always_comb begin
        cur_x    = {1'b0, cur};
        tgt_x    = {1'b0, tgt};
        up_x     = cur_x + STEP_X;
        dn_x     = cur_x - STEP_X;
        // Any cur at or below tgt+STEP lands exactly on tgt when moving down;
        // this comparison avoids ever evaluating a negative cur-STEP.
        dn_lim_x = tgt_x + STEP_X;
        next     = cur;
        if (cur_x < tgt_x) begin
            if (up_x >= tgt_x) begin
                next = tgt;
            end else begin
                next = up_x[DUTY_W-1:0];
            end
        end else if (cur_x > tgt_x) begin
            if (cur_x <= dn_lim_x) begin
                next = tgt;
            end else begin
                next = dn_x[DUTY_W-1:0];
            end
        end
    end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// servo_ramp_scheduler
// Memory-mapped ramp controller for three servo PWM duties. The CPU writes a
// target duty per channel; every TICK_DIV clocks a sweep FSM walks S1..S3 and
// moves each channel's current duty at most STEP toward its target through a
// single time-shared step unit. Current duties drive duty1..duty3 directly.
//
// Build option
//   SERVO_LIMIT_EN : when defined, written targets are clamped to
//                    [MIN_DUTY, MAX_DUTY] before being stored.
//
// Ports
//   clock  : single clock
//   reset  : asynchronous active-high reset
//   wEn    : CPU data-memory write strobe
//   addr   : CPU word address (11..13 targets, 14 status)
//   dataIn : CPU write data, bits [9:0] used
//   rdData : combinational read data for this block's addresses
//   rdHit  : addr decodes to this block
//   duty1..duty3 : registered current duty per servo
// -----------------------------------------------------------------------------
module servo_ramp_scheduler
    import servo_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int STEP      = 4,
    parameter int INIT_DUTY = 75,
    parameter int MIN_DUTY  = 50,
    parameter int MAX_DUTY  = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] rdData,
    output logic              rdHit,
    output logic [DUTY_W-1:0] duty1,
    output logic [DUTY_W-1:0] duty2,
    output logic [DUTY_W-1:0] duty3
);

`ifdef SERVO_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DUTY_W-1:0] INIT_D   = DUTY_W'(INIT_DUTY);
    localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);

    // Clamp applied to CPU-written targets when the limit option is built in
    function automatic logic [DUTY_W-1:0] limit_duty(input logic [DUTY_W-1:0] v);
        logic [DUTY_W-1:0] r;
        r = v;
        if (LIMIT_EN) begin
            if (v < MIN_D) begin
                r = MIN_D;
            end else if (v > MAX_D) begin
                r = MAX_D;
            end
        end
        return r;
    endfunction

    logic [CNT_W-1:0]     tick_cnt;
    logic                 tick;
    servo_state_t         state;
    logic [DUTY_W-1:0]    tgt [NUM_SERVO];
    logic [DUTY_W-1:0]    cur [NUM_SERVO];
    logic [NUM_SERVO-1:0] busy;
    logic [1:0]           sel;
    logic [DUTY_W-1:0]    step_cur;
    logic [DUTY_W-1:0]    step_tgt;
    logic [DUTY_W-1:0]    step_next;
    logic [DUTY_W-1:0]    wr_duty;
    logic                 unused_data;

    assign unused_data = ^dataIn[DATA_W-1:DUTY_W];
    assign wr_duty     = limit_duty(dataIn[DUTY_W-1:0]);

    // Tick divider: tick is a one-cycle pulse registered as the count wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    // Target registers: a write during a channel's own sweep state is stored
    // here but the step unit has already sampled the old value this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SERVO; i++) begin
                tgt[i] <= INIT_D;
            end
        end else if (wEn) begin
            case (addr)
                ADDR_TGT1: tgt[0] <= wr_duty;
                ADDR_TGT2: tgt[1] <= wr_duty;
                ADDR_TGT3: tgt[2] <= wr_duty;
                default:   ;
            endcase
        end
    end

    // Shared step unit operand mux
    always_comb begin
        sel      = state_chan(state);
        step_cur = cur[sel];
        step_tgt = tgt[sel];
    end

    servo_step_unit #(
        .STEP (STEP)
    ) u_step (
        .cur  (step_cur),
        .tgt  (step_tgt),
        .next (step_next)
    );

    // Sweep FSM: one channel per state; a tick outside IDLE is dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            for (int i = 0; i < NUM_SERVO; i++) begin
                cur[i] <= INIT_D;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_S1;
                    end
                end
                ST_S1: begin
                    cur[0] <= step_next;
                    state  <= ST_S2;
                end
                ST_S2: begin
                    cur[1] <= step_next;
                    state  <= ST_S3;
                end
                ST_S3: begin
                    cur[2] <= step_next;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SERVO; i++) begin
            busy[i] = (cur[i] != tgt[i]);
        end
    end

    // CPU read port
    always_comb begin
        rdData = '0;
        rdHit  = 1'b0;
        case (addr)
            ADDR_TGT1: begin
                rdData = {{(DATA_W-DUTY_W){1'b0}}, tgt[0]};
                rdHit  = 1'b1;
            end
            ADDR_TGT2: begin
                rdData = {{(DATA_W-DUTY_W){1'b0}}, tgt[1]};
                rdHit  = 1'b1;
            end
            ADDR_TGT3: begin
                rdData = {{(DATA_W-DUTY_W){1'b0}}, tgt[2]};
                rdHit  = 1'b1;
            end
            ADDR_STATUS: begin
                rdData = {{(DATA_W-NUM_SERVO){1'b0}}, busy};
                rdHit  = 1'b1;
            end
            default: ;
        endcase
    end

    assign duty1 = cur[0];
    assign duty2 = cur[1];
    assign duty3 = cur[2];

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_ramp_scheduler
// Directed bench for servo_ramp_scheduler with TICK_DIV=4, STEP=4,
// INIT_DUTY=75. Stimulus pushes each expected duty change (with the clock
// count at which it must appear) into a queue; a monitor pops an entry every
// time the duty outputs change and compares value and timing.
// With TICK_DIV=4, after reset release channel 1 updates on edges 6,10,14..,
// channel 2 on 7,11,15.. and channel 3 on 8,12,16..
// -----------------------------------------------------------------------------
module tb_servo_ramp_scheduler;

    logic        clock;
    logic        reset;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] rdData;
    logic        rdHit;
    logic [9:0]  duty1;
    logic [9:0]  duty2;
    logic [9:0]  duty3;

    typedef struct {
        int         cyc;
        logic [9:0] d1;
        logic [9:0] d2;
        logic [9:0] d3;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    servo_ramp_scheduler #(
        .TICK_DIV  (4),
        .STEP      (4),
        .INIT_DUTY (75),
        .MIN_DUTY  (50),
        .MAX_DUTY  (100)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .wEn    (wEn),
        .addr   (addr),
        .dataIn (dataIn),
        .rdData (rdData),
        .rdHit  (rdHit),
        .duty1  (duty1),
        .duty2  (duty2),
        .duty3  (duty3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge count since reset release: after posedge k, cyc == k
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input int a, input int b, input int d);
        exp_t e;
        e.cyc = c;
        e.d1  = 10'(a);
        e.d2  = 10'(b);
        e.d3  = 10'(d);
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        logic exp_hit;
        exp_hit = (a >= 12'd11) && (a <= 12'd14);
        wEn  = 1'b0;
        addr = a;
        #1;
        chk(name, rdData, exp);
        chk({name, "_hit"}, {31'b0, rdHit}, {31'b0, exp_hit});
    endtask

    // Drive a write at the current negedge; it lands on the next posedge
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wEn    = 1'b1;
        addr   = a;
        dataIn = d;
        @(negedge clock);
        wEn    = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Monitor: every change of the duty outputs consumes one expected entry
    initial begin : monitor
        logic [29:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev = {duty1, duty2, duty3};
            end else if ({duty1, duty2, duty3} != prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_duty_change actual=%0d/%0d/%0d required=no change (cyc=%0d)",
                             duty1, duty2, duty3, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("duty_change_cycle", cyc, e.cyc);
                    chk("duty1", {22'b0, duty1}, {22'b0, e.d1});
                    chk("duty2", {22'b0, duty2}, {22'b0, e.d2});
                    chk("duty3", {22'b0, duty3}, {22'b0, e.d3});
                end
                prev = {duty1, duty2, duty3};
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset  = 1'b1;
        wEn    = 1'b0;
        addr   = '0;
        dataIn = '0;

        // Reset state
        @(negedge clock);
        chk("reset_duty1", {22'b0, duty1}, 32'd75);
        chk("reset_duty2", {22'b0, duty2}, 32'd75);
        chk("reset_duty3", {22'b0, duty3}, 32'd75);
        rd(12'd14, 32'd0, "reset_status");
        @(negedge clock);
        rd(12'd11, 32'd75, "reset_tgt1");
        rd(12'd13, 32'd75, "reset_tgt3");
        rd(12'd20, 32'd0, "unmapped");
        @(negedge clock);
        #2 reset = 1'b0;

        // Channel 1 up-ramp 75 -> 85
        push(6, 79, 75, 75);
        push(10, 83, 75, 75);
        push(14, 85, 75, 75);
        wr(12'd11, 32'd85);
        wait_cyc(6);
        rd(12'd14, 32'd1, "busy_ch1_ramping");
        rd(12'd11, 32'd85, "tgt1_readback");
        wait_cyc(13);
        rd(12'd14, 32'd1, "busy_ch1_before_arrive");
        wait_cyc(14);
        rd(12'd14, 32'd0, "busy_ch1_cleared");

        // Channel 2 down-ramp 75 -> 66
        wait_cyc(16);
        push(19, 85, 71, 75);
        push(23, 85, 67, 75);
        push(27, 85, 66, 75);
        wr(12'd12, 32'd66);
        wait_cyc(19);
        rd(12'd14, 32'd2, "busy_ch2_ramping");

        // Channel 3 target written on the S3 edge: no move until next tick
        wait_cyc(31);
        push(36, 85, 66, 79);
        wr(12'd13, 32'd95);
        chk("s3_write_duty3_hold", {22'b0, duty3}, 32'd75);
        rd(12'd14, 32'd4, "busy_ch3_pending");
        rd(12'd13, 32'd95, "tgt3_readback");

        // Reset in the middle of a sweep with targets pending
        wait_cyc(36);
        push(38, 81, 66, 79);
        wr(12'd11, 32'd60);
        wait_cyc(38);
        #2 reset = 1'b1;
        #1;
        chk("midsweep_reset_duty1", {22'b0, duty1}, 32'd75);
        chk("midsweep_reset_duty2", {22'b0, duty2}, 32'd75);
        chk("midsweep_reset_duty3", {22'b0, duty3}, 32'd75);
        @(negedge clock);
        rd(12'd11, 32'd75, "midsweep_reset_tgt1");
        rd(12'd12, 32'd75, "midsweep_reset_tgt2");
        rd(12'd13, 32'd75, "midsweep_reset_tgt3");
        rd(12'd14, 32'd0, "midsweep_reset_status");
        @(negedge clock);
        #2 reset = 1'b0;

        // FSM restarted from IDLE: channel 2 follows the normal schedule
        push(7, 75, 79, 75);
        push(11, 75, 80, 75);
        wr(12'd12, 32'd80);
        wait_cyc(12);
        rd(12'd14, 32'd0, "post_reset_settled");
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;

`ifdef SERVO_LIMIT_EN
        // Out-of-range target is clamped to MAX_DUTY
        push(6, 79, 75, 75);
        push(10, 83, 75, 75);
        push(14, 87, 75, 75);
        push(18, 91, 75, 75);
        push(22, 95, 75, 75);
        push(26, 99, 75, 75);
        push(30, 100, 75, 75);
        wr(12'd11, 32'd200);
        rd(12'd11, 32'd100, "limit_tgt1_clamped");
        wait_cyc(34);
        rd(12'd14, 32'd0, "limit_ch1_settled");
        chk("limit_duty1_final", {22'b0, duty1}, 32'd100);
`else
        // Without the limit option the written value is stored unmodified
        wr(12'd11, 32'd200);
        rd(12'd11, 32'd200, "nolimit_tgt1_raw");
        wait_cyc(3);
        chk("nolimit_duty1_unchanged", {22'b0, duty1}, 32'd75);
`endif

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp_scheduler.md
SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clocks per ramp tick (10 ms at 50 MHz), minimum 4.
REQ-002 SHALL have parameter STEP, default 4, maximum duty change per channel per tick, range 1..1023.
REQ-003 SHALL have parameter INIT_DUTY, default 75, reset value of every target and current duty.
REQ-004 SHALL have parameters MIN_DUTY and MAX_DUTY, defaults 50 and 100, clamp bounds, used only under SERVO_LIMIT_EN.
REQ-005 SHALL have port clock, input, 1 bit, single clock; reset is asynchronous and active-high.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port wEn, input, 1 bit, CPU data-memory write strobe.
REQ-008 SHALL have port addr, input, 12 bits, CPU data-memory word address.
REQ-009 SHALL have port dataIn, input, 32 bits, CPU write data; bits [9:0] are used.
REQ-010 SHALL have port rdData, output, 32 bits, combinational read data for this block's addresses.
REQ-011 SHALL have port rdHit, output, 1 bit, high when addr decodes to this block.
REQ-012 SHALL have ports duty1, duty2, duty3, each output, 10 bits, registered current duty per servo.

Function
REQ-013 SHALL decode addresses 11, 12 and 13 as target registers for channels 1-3, and address 14 as the status register.
REQ-014 SHALL load target[n] from dataIn[9:0] on a clock edge where wEn=1 and addr equals that channel's target address.
REQ-015 SHALL drive rdData={22'b0,target[n]} for addresses 11-13, {29'b0,busy[3:1]} for address 14, zero otherwise; rdHit=1 only for addresses 11-14.
REQ-016 SHALL define busy[n]=(cur[n]!=target[n]), evaluated combinationally.
REQ-017 SHALL run a free counter 0..TICK_DIV-1 and assert a one-cycle tick when it wraps to 0.
REQ-018 SHALL implement FSM IDLE -> S1 -> S2 -> S3 -> IDLE: leave IDLE on tick; each Sn updates cur[n] in one cycle through a single shared step unit.
REQ-019 SHALL update in Sn: if cur<target, cur=min(cur+STEP,target); if cur>target, cur=max(cur-STEP,target); else hold; arithmetic is 11-bit, no wrap.
REQ-020 SHALL let a target write in the same cycle as Sn for that channel take effect on the next tick; that Sn uses the old target.
REQ-021 SHALL ignore, not queue, a tick arriving while not in IDLE; TICK_DIV>=4 guarantees this never occurs.
REQ-022 SHALL drive dutyN=cur[N] directly from registers, giving zero added output latency.

Reset
REQ-023 SHALL, on reset assertion, asynchronously set target and cur of all channels to INIT_DUTY, the tick counter to 0 and the FSM to IDLE.
REQ-024 SHALL abandon an in-progress S1-S3 sweep when reset is asserted mid-sweep, with no partial update retained.

Configuration
REQ-025 SHALL, with SERVO_LIMIT_EN defined, clamp written targets to [MIN_DUTY,MAX_DUTY] before storing, and the readback returns the clamped value.
REQ-026 SHALL, without SERVO_LIMIT_EN, store dataIn[9:0] unmodified; MIN_DUTY and MAX_DUTY are then unused.

Structure
REQ-027 SHALL place NUM_SERVO=3, DUTY_W=10, the address constants 11-14 and the FSM state encoding in shared package servo_pkg.
REQ-028 SHALL instantiate one sub-module, servo_step_unit, as a combinational saturating step toward target, used once and time-shared across channels.

Verification (bench uses TICK_DIV=4, STEP=4, INIT_DUTY=75, no SERVO_LIMIT_EN unless stated)
REQ-029 SHALL cover: reset, then read addr 14 -> rdData=0; duty1-3 all equal 75.
REQ-030 SHALL cover: write 85 to addr 11 -> over successive ticks duty1 is 79, 83, 85, then holds; busy[1] clears in the tick it reaches 85.
REQ-031 SHALL cover: write 66 to addr 12 -> duty2 is 71, 67, 66; duty1 and duty3 stay unchanged.
REQ-032 SHALL cover: write addr 13 in the same cycle as state S3 -> duty3 is unchanged on that tick and moves one STEP on the next tick.
REQ-033 SHALL cover: assert reset during S2 with targets pending -> all duties and targets equal 75 immediately, FSM returns to IDLE.
REQ-034 SHALL cover: with SERVO_LIMIT_EN, write 200 to addr 11 -> readback is 100 and duty1 ramps to and stops at 100.
